// File: rtl/wash_phase_timer.sv
// Multi-round wash-phase timer: times up to 2**ROUND_W rounds of a latched length, with pause and soft reset.
// Define WASH_TIMER_REMAIN_EN to add the registered remain_o countdown output.
module wash_phase_timer #(
  parameter int unsigned            CNT_W    = 32,
  parameter int unsigned            ROUND_W  = 2,
  parameter logic [CNT_W-1:0]       TICKS_F0 = CNT_W'(32'h11E1A300),
  parameter logic [CNT_W-1:0]       TICKS_F1 = CNT_W'(32'h23C34600),
  parameter logic [CNT_W-1:0]       TICKS_F2 = CNT_W'(32'h47868C00),
  parameter logic [CNT_W-1:0]       TICKS_F3 = CNT_W'(32'hFA56EA00)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               soft_rst_n_i,
  input  logic               start_i,
  input  logic               pause_i,
  input  logic [1:0]         clk_freq_i,
  input  logic [ROUND_W-1:0] rounds_i,
  output logic               busy_o,
  output logic               paused_o,
  output logic               round_done_o,
  output logic               done_o,
  output logic [ROUND_W-1:0] round_idx_o
`ifdef WASH_TIMER_REMAIN_EN
  ,output logic [CNT_W-1:0]  remain_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   stop_q, stop_d;
  logic [ROUND_W-1:0] rounds_q, rounds_d;
  logic [ROUND_W-1:0] idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               paused_q, paused_d;
  logic               round_done_q, round_done_d;
  logic               done_q, done_d;

  function automatic logic [CNT_W-1:0] ticks_sel(input logic [1:0] sel);
    case (sel)
      2'b00:   ticks_sel = TICKS_F0;
      2'b01:   ticks_sel = TICKS_F1;
      2'b10:   ticks_sel = TICKS_F2;
      default: ticks_sel = TICKS_F3;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    q_d          = q_q;
    stop_d       = stop_q;
    rounds_d     = rounds_q;
    idx_d        = idx_q;
    round_done_d = 1'b0;
    done_d       = 1'b0;

    if (!soft_rst_n_i) begin
      state_d  = IDLE;
      q_d      = '0;
      stop_d   = '0;
      rounds_d = '0;
      idx_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            stop_d   = ticks_sel(clk_freq_i);
            rounds_d = (rounds_i == '0) ? ROUND_W'(1) : rounds_i;
            q_d      = '0;
            idx_d    = '0;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (pause_i) begin
            state_d = PAUSE;
          end else if (q_q == stop_q - CNT_W'(1)) begin
            q_d          = '0;
            round_done_d = 1'b1;
            if (idx_q == rounds_q - ROUND_W'(1)) begin
              done_d  = 1'b1;
              idx_d   = '0;
              state_d = IDLE;
            end else begin
              idx_d = idx_q + ROUND_W'(1);
            end
          end else begin
            q_d = q_q + CNT_W'(1);
          end
        end
        PAUSE: begin
          // Leaving PAUSE spends one cycle without counting.
          if (!pause_i) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d   = (state_d != IDLE);
    paused_d = (state_d == PAUSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      q_q          <= '0;
      stop_q       <= '0;
      rounds_q     <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      paused_q     <= 1'b0;
      round_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q      <= state_d;
      q_q          <= q_d;
      stop_q       <= stop_d;
      rounds_q     <= rounds_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      paused_q     <= paused_d;
      round_done_q <= round_done_d;
      done_q       <= done_d;
    end
  end

  assign busy_o       = busy_q;
  assign paused_o     = paused_q;
  assign round_done_o = round_done_q;
  assign done_o       = done_q;
  assign round_idx_o  = idx_q;

`ifdef WASH_TIMER_REMAIN_EN
  logic [CNT_W-1:0] remain_q, remain_d;

  // Tracks q on the same edge, so it reads stop..1 through a round and 0 when idle.
  assign remain_d = busy_d ? (stop_d - q_d) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) remain_q <= '0;
    else        remain_q <= remain_d;
  end

  assign remain_o = remain_q;
`endif

endmodule

// File: tb/tb_wash_phase_timer.sv
// Scoreboard bench for wash_phase_timer with small round lengths (4/6/8/10 cycles).
module tb_wash_phase_timer;
  localparam int CNT_W   = 32;
  localparam int ROUND_W = 2;

  logic               clk = 1'b0;
  logic               rst_n, soft_rst_n, start, pause;
  logic [1:0]         clk_freq;
  logic [ROUND_W-1:0] rounds;
  logic               busy, paused, round_done, done;
  logic [ROUND_W-1:0] round_idx;
`ifdef WASH_TIMER_REMAIN_EN
  logic [CNT_W-1:0]   remain;
`endif

  wash_phase_timer #(
    .CNT_W(CNT_W), .ROUND_W(ROUND_W),
    .TICKS_F0(32'd4), .TICKS_F1(32'd6), .TICKS_F2(32'd8), .TICKS_F3(32'd10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .soft_rst_n_i(soft_rst_n), .start_i(start),
    .pause_i(pause), .clk_freq_i(clk_freq), .rounds_i(rounds),
    .busy_o(busy), .paused_o(paused), .round_done_o(round_done),
    .done_o(done), .round_idx_o(round_idx)
`ifdef WASH_TIMER_REMAIN_EN
    , .remain_o(remain)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    bit last;
    int at;
  } exp_t;

  exp_t               sb[$];
  int                 tests = 0;
  int                 fails = 0;
  int                 busy_cnt = 0;
  logic [ROUND_W-1:0] idx_prev = '0;
  exp_t               e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: runs on the falling edge; stimulus acts 1 time unit later.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (round_done) begin
        if (sb.size() == 0) begin
          check("unexpected_round_done", round_done, 1'b0);
        end else begin
          e = sb.pop_front();
          check("rd_cycle", cyc, e.at);
          check("rd_round_idx", 32'(idx_prev), e.idx);
          check("rd_done_flag", 32'(done), 32'(e.last));
          check("rd_idx_after", 32'(round_idx), e.last ? 0 : e.idx + 1);
          if (done) check("done_busy_low", 32'(busy), 0);
        end
      end else if (done) begin
        check("done_without_round_done", 32'(done), 0);
      end
      idx_prev = round_idx;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int s, input int len, input int n);
    for (int r = 0; r < n; r++)
      sb.push_back('{idx: r, last: (r == n - 1), at: s + (r + 1) * len});
  endtask

  task automatic do_start(input logic [1:0] f, input logic [ROUND_W-1:0] n, output int s);
    start    = 1'b1;
    clk_freq = f;
    rounds   = n;
    busy_cnt = 0;
    s        = cyc + 1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check({name, "_ends"}, 32'(busy), 0);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic check_cleared(input string name);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_paused"}, 32'(paused), 0);
    check({name, "_round_done"}, 32'(round_done), 0);
    check({name, "_done"}, 32'(done), 0);
    check({name, "_round_idx"}, 32'(round_idx), 0);
`ifdef WASH_TIMER_REMAIN_EN
    check({name, "_remain"}, remain, 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    rst_n = 1'b0; soft_rst_n = 1'b1; start = 1'b0; pause = 1'b0;
    clk_freq = 2'd0; rounds = '0;
    repeat (2) tick();
    check_cleared("reset");
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_busy", 32'(busy), 0);

    // Single round of 4.
    do_start(2'd0, 2'd1, s);
    push(s, 4, 1);
    wait_idle("t1");
    check("t1_busy_cycles", busy_cnt, 4);
    repeat (2) tick();

    // Three rounds of 6.
    do_start(2'd1, 2'd3, s);
    push(s, 6, 3);
    wait_idle("t2");
    check("t2_busy_cycles", busy_cnt, 18);
    repeat (2) tick();

    // rounds=0 acts as one round of 8.
    do_start(2'd2, 2'd0, s);
    push(s, 8, 1);
    wait_idle("t3");
    check("t3_busy_cycles", busy_cnt, 8);
    repeat (2) tick();

    // Pause for 5 cycles after 2 counts: done 6 cycles late.
    do_start(2'd0, 2'd1, s);
    push(s, 10, 1);
    repeat (2) tick();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_paused_high", 32'(paused), 1);
      check("t4_busy_in_pause", 32'(busy), 1);
`ifdef WASH_TIMER_REMAIN_EN
      check("t4_remain_hold", remain, 2);
`endif
    end
    pause = 1'b0;
    tick();
    check("t4_paused_low", 32'(paused), 0);
`ifdef WASH_TIMER_REMAIN_EN
    check("t4_remain_resume", remain, 2);
`endif
    wait_idle("t4");
    check("t4_busy_cycles", busy_cnt, 10);
    repeat (2) tick();

    // Soft reset mid round 2 with coincident start; start must be lost.
    do_start(2'd1, 2'd3, s);
    sb.push_back('{idx: 0, last: 1'b0, at: s + 6});
    repeat (8) tick();
    soft_rst_n = 1'b0;
    start      = 1'b1;
    clk_freq   = 2'd0;
    tick();
    check_cleared("t5_soft");
    soft_rst_n = 1'b1;
    start      = 1'b0;
    repeat (3) tick();
    check("t5_start_lost", 32'(busy), 0);
    check("t5_sb_empty", sb.size(), 0);
    do_start(2'd1, 2'd3, s);
    push(s, 6, 3);
    wait_idle("t5_fresh");
    check("t5_busy_cycles", busy_cnt, 18);
    repeat (2) tick();

    // Mid-phase clk_freq/rounds change and extra start are ignored.
    do_start(2'd0, 2'd2, s);
    push(s, 4, 2);
    repeat (2) tick();
    clk_freq = 2'd3;
    rounds   = 2'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("t6_still_busy", 32'(busy), 1);
    wait_idle("t6");
    check("t6_busy_cycles", busy_cnt, 8);
    repeat (2) tick();

    // Back-to-back: start accepted in the cycle done is high.
    do_start(2'd0, 2'd1, s);
    push(s, 4, 1);
    wait_idle("t7a");
    do_start(2'd0, 2'd1, s);
    push(s, 4, 1);
    wait_idle("t7b");
    check("t7_busy_cycles", busy_cnt, 4);
    repeat (2) tick();

    // Asynchronous reset mid-phase aborts without done.
    do_start(2'd1, 2'd3, s);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_cleared("t8_async");
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("t8_stays_idle", 32'(busy), 0);
    check("t8_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wash_phase_timer.md
Name: wash_phase_timer

Overview:
- Parametrised multi-round wash-phase timer, successor to the single-shot washing counter.
- Times N back-to-back rounds of a phase. Round length is selected by the clock-frequency code and latched at start.
- Supports pause/resume and a synchronous soft reset. Emits per-round and end-of-phase pulses.
- Sits between the washing-machine control FSM and the clock-frequency select logic.

Parameters:
- CNT_W, 32, width of the tick counter and of every TICKS_Fx value.
- ROUND_W, 2, width of the rounds and round_idx fields.
- TICKS_F0, 32'h11E1A300, round length in cycles for clk_freq=2'b00. Must be >=1.
- TICKS_F1, 32'h23C34600, round length in cycles for clk_freq=2'b01.
- TICKS_F2, 32'h47868C00, round length in cycles for clk_freq=2'b10.
- TICKS_F3, 32'hFA56EA00, round length in cycles for clk_freq=2'b11.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- soft_rst_n  in  1  synchronous soft reset, active-low.
- start  in  1  start request, sampled in IDLE only.
- pause  in  1  level; high freezes timing.
- clk_freq  in  2  selects TICKS_F0..F3; latched at start.
- rounds  in  ROUND_W  number of rounds; latched at start; 0 is treated as 1.
- busy  out  1  high while state is RUN or PAUSE.
- paused  out  1  high while state is PAUSE.
- round_done  out  1  one-cycle pulse at the end of each round.
- done  out  1  one-cycle pulse at the end of the last round.
- round_idx  out  ROUND_W  index of the current round, starting at 0.

Behaviour:
- All outputs are registered.
- Reset values (rst_n low, or soft_rst_n low at a clock edge): state=IDLE, q=0, round_idx=0; busy, paused, round_done and done all 0.
- Latched stop_l and rounds_l are cleared to 0 on reset.
- Priority order: rst_n > soft_rst_n > all other inputs. Start coincident with soft_rst_n low is lost.
- States: IDLE, RUN, PAUSE.
- IDLE:
  - start=1 -> latch stop_l = TICKS_F[clk_freq] and rounds_l = max(rounds,1).
  - q=0, round_idx=0, go to RUN.
  - pause is ignored in IDLE.
- RUN:
  - pause=1 -> go to PAUSE, no increment this cycle.
  - Otherwise, if q == stop_l-1:
    - q <= 0 and round_done <= 1.
    - If round_idx == rounds_l-1: done <= 1, round_idx <= 0, go to IDLE.
    - Else round_idx <= round_idx+1 and stay in RUN.
  - Otherwise q <= q+1.
- PAUSE:
  - q and round_idx hold.
  - pause=0 -> go to RUN with no increment in that cycle, so each pause episode costs at least 1 extra cycle.
- Round length: exactly stop_l unpaused RUN cycles. The first counting cycle is the one after start is accepted.
- Phase latency from start (unpaused): rounds_l*stop_l cycles until the done pulse is visible.
- start in RUN or PAUSE is ignored.
- clk_freq and rounds changes mid-phase are ignored.
- A new start is accepted in the cycle done is high, since state is already IDLE.
- TICKS_Fx=1: round_done pulses every RUN cycle.
- No counter wrap: q never exceeds stop_l-1.
- Asynchronous reset mid-phase aborts the phase with no done pulse.

Optional Feature:
- Macro WASH_TIMER_REMAIN_EN.
- When defined: adds output remain [CNT_W-1:0], registered, equal to stop_l-q while busy and 0 in IDLE or on reset. It updates in the same cycle as q, so it counts down through stop_l..1 each round and holds during PAUSE.
- When undefined: the port does not exist and no subtractor is built.

Test Plan:
- TICKS_F0=4, rounds=1, clk_freq=0, start pulse -> busy rises next cycle; round_done and done pulse together 4 cycles after busy rises; busy low the same cycle.
- TICKS_F1=6, rounds=3, clk_freq=1 -> round_done every 6 cycles with round_idx 0,1,2; a single done pulse with the third round_done; 18 busy cycles total.
- rounds=0, clk_freq=2, TICKS_F2=8 -> behaves as 1 round; done after 8 busy cycles.
- TICKS_F0=4, pause held 5 cycles starting after 2 counts -> q frozen at 2 and paused=1 for 5 cycles; done arrives 6 cycles later than unpaused; with WASH_TIMER_REMAIN_EN, remain holds 2.
- soft_rst_n low for 1 cycle mid-round 2, also with start coincident -> all outputs return to 0 and state IDLE; no done pulse; the following start times the full phase afresh.
- clk_freq changed 0->3 mid-phase and start re-pulsed while busy -> round length stays TICKS_F0; the extra start is ignored.
